mem_bridge: RTL and testbench

Memory bus bridge between the `cpu` core's data port and a variable-latency synchronous memory. It posts CPU writes into a small write buffer so the core does not wait on them. CPU reads are held off until the buffer has drained, which preserves program order. Reads complete through a req/ack handshake with the memory, with the CPU stalled on `cpu_ready`.

---
 rtl/mem_bridge_pkg.sv | 15 +
 rtl/mem_bridge_wbuf_fifo.sv | 70 +++++++
 rtl/mem_bridge.sv | 127 ++++++++++++
 tb/tb_mem_bridge.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bridge_pkg.sv
// Shared types and default sizing for the mem_bridge posted-write bridge.
package mem_bridge_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int ADDR_W_DEF     = 32;
  localparam int WBUF_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    RESP = 2'd3
  } mb_state_t;

endpackage

// File: rtl/mem_bridge_wbuf_fifo.sv
// Synchronous FIFO of posted {address, data} writes, drained in order by mem_bridge.
module wbuf_fifo
  import mem_bridge_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = WBUF_DEPTH_DEF
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [ADDR_W-1:0]        push_addr,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [ADDR_W-1:0]        head_addr,
  output logic [DATA_W-1:0]        head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_MAX = (PTR_W + 1)'(DEPTH);

  logic [ADDR_W+DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]           count_q, count_d;
  logic                     push_ok, pop_ok;

  assign full      = (count_q == CNT_MAX);
  assign empty     = (count_q == '0);
  assign push_ok   = push & ~full;
  assign pop_ok    = pop & ~empty;
  assign count     = count_q;
  assign head_addr = mem_q[rd_ptr_q][ADDR_W+DATA_W-1:DATA_W];
  assign head_data = mem_q[rd_ptr_q][DATA_W-1:0];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    else         wr_ptr_d = wr_ptr_q;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    else         rd_ptr_d = rd_ptr_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_ok) mem_q[wr_ptr_q] <= {push_addr, push_data};
    end
  end

endmodule

// File: rtl/mem_bridge.sv
// CPU-to-memory bridge: posted writes through a small buffer, reads held until it drains.
module mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int WBUF_DEPTH = WBUF_DEPTH_DEF
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          cpu_valid,
  input  logic                          cpu_we,
  input  logic [ADDR_W-1:0]             cpu_address,
  input  logic [DATA_W-1:0]             cpu_datao,
  output logic [DATA_W-1:0]             cpu_data,
  output logic                          cpu_ready,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_address,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata,
  input  logic                          mem_ack,
  output logic [$clog2(WBUF_DEPTH):0]   wbuf_count
);

  mb_state_t          state_q, state_d;
  logic               mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d, cpu_data_q, cpu_data_d;
  logic               push, pop, fifo_full, fifo_empty;
  logic [ADDR_W-1:0]  head_addr;
  logic [DATA_W-1:0]  head_data;

  wbuf_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(WBUF_DEPTH)) u_wbuf (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_addr (cpu_address),
    .push_data (cpu_datao),
    .pop       (pop),
    .head_addr (head_addr),
    .head_data (head_data),
    .count     (wbuf_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Full is judged on the registered count, so a same-cycle pop never frees a slot early.
  assign push        = cpu_valid & cpu_we & ~fifo_full;
  assign cpu_ready   = reset & (push | (state_q == RESP));
  assign cpu_data    = cpu_data_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_address = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_data_d  = cpu_data_q;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        // Draining wins over a waiting read to keep program order.
        if (!fifo_empty) begin
          mem_addr_d  = head_addr;
          mem_wdata_d = head_data;
          mem_we_d    = 1'b1;
          mem_req_d   = 1'b1;
          state_d     = WR;
        end else if (cpu_valid && !cpu_we) begin
          mem_addr_d  = cpu_address;
          mem_we_d    = 1'b0;
          mem_req_d   = 1'b1;
          state_d     = RD;
        end else begin
          state_d     = IDLE;
        end
      end
      WR: begin
        if (mem_ack) begin
          pop       = 1'b1;
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end else begin
          state_d   = WR;
        end
      end
      RD: begin
        if (mem_ack) begin
          cpu_data_d = mem_rdata;
          mem_req_d  = 1'b0;
          state_d    = RESP;
        end else begin
          state_d    = RD;
        end
      end
      RESP:    state_d = IDLE;
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_data_q  <= cpu_data_d;
    end
  end

endmodule

// File: tb/tb_mem_bridge.sv
// Scoreboard bench for mem_bridge: reference memory model, expected-bus and read-data queues.
module tb_mem_bridge;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_valid, cpu_we, cpu_ready, mem_req, mem_we, mem_ack;
  logic [31:0] cpu_address, cpu_datao, cpu_data, mem_address, mem_wdata, mem_rdata;
  logic [2:0]  wbuf_count;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } bus_t;

  bus_t        exp_bus_q[$];
  logic [31:0] exp_rd_q[$];
  logic [31:0] store   [256];
  logic [31:0] ref_mem [256];
  int          model_cnt;
  int          n_checks = 0;
  int          n_fails  = 0;
  bit          ack_hold;
  int          ack_wait;

  mem_bridge #(.DATA_W(32), .ADDR_W(32), .WBUF_DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .cpu_valid   (cpu_valid),
    .cpu_we      (cpu_we),
    .cpu_address (cpu_address),
    .cpu_datao   (cpu_datao),
    .cpu_data    (cpu_data),
    .cpu_ready   (cpu_ready),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .wbuf_count  (wbuf_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Memory responder: ack after a chosen number of wait cycles, data from the memory image.
  initial begin : responder
    int left;
    bit busy;
    busy = 1'b0; left = 0; mem_ack = 1'b0; mem_rdata = 32'h0;
    forever begin
      @(posedge clock); #1;
      if (!reset || !mem_req) begin
        mem_ack = 1'b0; busy = 1'b0;
      end else begin
        if (!busy) begin
          busy = 1'b1;
          left = (ack_wait < 0) ? int'($urandom_range(0, 3)) : ack_wait;
        end
        if (ack_hold) mem_ack = 1'b0;
        else if (left == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = store[mem_address[7:0]];
        end else begin
          mem_ack = 1'b0;
          left--;
        end
      end
    end
  end

  // Monitor: occupancy model, write acceptance, bus order/stability, read data.
  initial begin : monitor
    bus_t        e;
    logic        pr, pwe, pack, exp_rdy;
    logic [31:0] pa, pw;
    pr = 1'b0; pwe = 1'b0; pack = 1'b0; pa = 32'h0; pw = 32'h0;
    forever begin
      @(negedge clock);
      if (reset) begin
        check("wbuf_count", wbuf_count, model_cnt);
        if (mem_req && !mem_we) check("read_while_buffered", model_cnt, 0);
        if (mem_req && pr && !pack) begin
          check("stable_addr", mem_address, pa);
          check("stable_we", mem_we, pwe);
          check("stable_wdata", mem_wdata, pw);
        end
        if (cpu_valid && cpu_we) begin
          exp_rdy = (model_cnt != DEPTH);
          check("write_ready", cpu_ready, exp_rdy);
          if (exp_rdy) begin
            exp_bus_q.push_back('{we: 1'b1, addr: cpu_address, data: cpu_datao});
            ref_mem[cpu_address[7:0]] = cpu_datao;
            model_cnt++;
          end
        end
        if (cpu_valid && !cpu_we && cpu_ready) begin
          if (exp_rd_q.size() == 0) check("unexpected_read_resp", 1, 0);
          else check("read_data", cpu_data, exp_rd_q.pop_front());
        end
        if (mem_req && mem_ack) begin
          if (exp_bus_q.size() == 0) check("unexpected_bus_txn", 1, 0);
          else begin
            e = exp_bus_q.pop_front();
            check("bus_we", mem_we, e.we);
            check("bus_addr", mem_address, e.addr);
            if (e.we) begin
              check("bus_wdata", mem_wdata, e.data);
              store[mem_address[7:0]] = mem_wdata;
              model_cnt--;
            end
          end
        end
        pr = mem_req; pwe = mem_we; pack = mem_ack; pa = mem_address; pw = mem_wdata;
      end else begin
        pr = 1'b0;
      end
    end
  end

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, output int lat);
    cpu_valid = 1'b1; cpu_we = 1'b1; cpu_address = a; cpu_datao = d; lat = 0;
    @(negedge clock);
    while (!cpu_ready && lat < 200) begin lat++; @(negedge clock); end
    if (!cpu_ready) check("write_timeout", 1, 0);
    @(posedge clock); #1;
    cpu_valid = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, output int lat);
    exp_bus_q.push_back('{we: 1'b0, addr: a, data: 32'h0});
    exp_rd_q.push_back(ref_mem[a[7:0]]);
    cpu_valid = 1'b1; cpu_we = 1'b0; cpu_address = a; lat = 0;
    @(negedge clock);
    while (!cpu_ready && lat < 200) begin lat++; @(negedge clock); end
    if (!cpu_ready) check("read_timeout", 1, 0);
    @(posedge clock); #1;
    cpu_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clock);
    while ((wbuf_count != 3'd0 || mem_req) && n < 500) begin n++; @(negedge clock); end
    if (n >= 500) check("drain_timeout", 1, 0);
    @(posedge clock); #1;
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int          lat;
    logic [31:0] a;
    cpu_valid = 1'b0; cpu_we = 1'b0; cpu_address = 32'h0; cpu_datao = 32'h0;
    ack_hold = 1'b0; ack_wait = 0; model_cnt = 0;
    for (int i = 0; i < 256; i++) begin store[i] = 32'h0; ref_mem[i] = 32'h0; end

    repeat (3) @(posedge clock);
    #1;
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_address", mem_address, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_cpu_data", cpu_data, 0);
    check("rst_cpu_ready", cpu_ready, 0);
    check("rst_wbuf_count", wbuf_count, 0);
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;

    // Single read, ack in the first RD cycle.
    store[8'h40] = 32'hDEADBEEF; ref_mem[8'h40] = 32'hDEADBEEF;
    do_read(32'h40, lat);
    check("single_read_latency", lat, 2);

    // Fill the buffer with memory stalled, then release one ack.
    ack_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_write(32'h10 + 32'(i), 32'(i + 1), lat);
      check("fill_latency", lat, 0);
    end
    cpu_valid = 1'b1; cpu_we = 1'b1; cpu_address = 32'h14; cpu_datao = 32'd5;
    @(negedge clock);
    check("fifth_write_stalled", cpu_ready, 0);
    check("fifth_write_count", wbuf_count, 4);
    ack_hold = 1'b0;
    @(posedge clock); #1;
    do_write(32'h14, 32'd5, lat);
    check("fifth_write_after_pop", lat, 1);
    wait_idle();

    // Read after write to the same address.
    do_write(32'h20, 32'hA5A5A5A5, lat);
    do_read(32'h20, lat);
    check("read_behind_write_latency", lat, 4);
    wait_idle();

    // Three wait states on a write and a read.
    ack_wait = 3;
    do_write(32'h30, 32'h12345678, lat);
    check("ws_write_latency", lat, 0);
    wait_idle();
    do_read(32'h30, lat);
    check("ws_read_latency", lat, 5);
    ack_wait = 0;
    wait_idle();

    // Ten writes with immediate acks; pointers wrap more than twice.
    for (int i = 0; i < 10; i++) begin
      do_write(32'h50 + 32'(i), $urandom, lat);
      check("wrap_write_latency", lat, 0);
      @(negedge clock);
      check("wrap_count_le2", (wbuf_count <= 3'd2), 1);
      @(posedge clock); #1;
    end
    wait_idle();

    // Random mix of reads and writes with random wait states.
    ack_wait = -1;
    for (int i = 0; i < 300; i++) begin
      a = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 2) != 0) do_write(a, $urandom, lat);
      else do_read(a, lat);
      if ($urandom_range(0, 3) == 0) begin @(posedge clock); #1; end
    end
    wait_idle();
    ack_wait = 0;

    // Reset while a read is outstanding on the bus.
    ack_hold = 1'b1;
    cpu_valid = 1'b1; cpu_we = 1'b0; cpu_address = 32'h60;
    lat = 0;
    @(negedge clock);
    while (!mem_req && lat < 50) begin lat++; @(negedge clock); end
    check("mid_read_req_seen", mem_req, 1);
    #2 reset = 1'b0;
    #1;
    check("mid_reset_mem_req", mem_req, 0);
    check("mid_reset_cpu_ready", cpu_ready, 0);
    check("mid_reset_wbuf_count", wbuf_count, 0);
    cpu_valid = 1'b0;
    exp_bus_q.delete(); exp_rd_q.delete(); model_cnt = 0;
    ack_hold = 1'b0;
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    store[8'h60] = 32'hCAFEF00D; ref_mem[8'h60] = 32'hCAFEF00D;
    do_read(32'h60, lat);
    check("post_reset_read_latency", lat, 2);
    wait_idle();
    check("bus_queue_empty", exp_bus_q.size(), 0);
    check("read_queue_empty", exp_rd_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
